// File: rtl/shreg_seq.sv
// Sample-to-group sequencer for an unrolled shift-buffer FIR front end.
// Packs UNR samples per shift, tracks warm-up, applies window backpressure and drains on flush.
module shreg_seq #(
  parameter int unsigned DWIDTH = 15,
  parameter int unsigned UNR    = 4,
  parameter int unsigned NTAP   = 37
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  input  logic [DWIDTH-1:0]       in_data_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  input  logic                    win_ready_i,
  output logic                    sh_en_o,
  output logic [DWIDTH*UNR-1:0]   sh_din_o,
  output logic                    win_valid_o,
  output logic                    busy_flush_o,
  output logic                    flush_done_o,
  output logic [3:0]              grp_cnt_o
);

  localparam int unsigned BUFLEN    = NTAP - 1 + UNR;
  localparam int unsigned WARM_GRP  = (BUFLEN + UNR - 1) / UNR;
  localparam int unsigned FLUSH_GRP = (NTAP - 1 + UNR - 1) / UNR;
  localparam int unsigned LW        = (UNR > 1) ? $clog2(UNR) : 1;
  localparam int unsigned FW        = $clog2(FLUSH_GRP + 1);

  typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

  state_e                        state_q, state_d;
  logic [LW-1:0]                 lcnt_q, lcnt_d;
  logic [3:0]                    grp_q, grp_d;
  logic [UNR-1:0][DWIDTH-1:0]    lane_q, lane_d, lane_wr;
  logic                          pend_q, pend_d;
  logic                          sh_en_q, sh_en_d;
  logic [DWIDTH*UNR-1:0]         sh_din_q, sh_din_d;
  logic                          wv_q, wv_d;
  logic [FW-1:0]                 fcnt_q, fcnt_d;
  logic                          from_run_q, from_run_d;
  logic                          done_q, done_d;
  logic                          rdy_q;
  logic                          block;
  logic                          accept;

  // A completed group waits in the lane register (pend_q) while a window is held.
  assign in_ready_o   = rdy_q && (state_q != StFlush) && !pend_q && !flush_i;
  assign sh_en_o      = sh_en_q;
  assign sh_din_o     = sh_din_q;
  assign win_valid_o  = wv_q;
  assign busy_flush_o = (state_q == StFlush);
  assign flush_done_o = done_q;
  assign grp_cnt_o    = grp_q;

  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    grp_d      = grp_q;
    lane_d     = lane_q;
    pend_d     = pend_q;
    sh_en_d    = 1'b0;
    sh_din_d   = sh_din_q;
    wv_d       = wv_q;
    fcnt_d     = fcnt_q;
    from_run_d = from_run_q;
    done_d     = 1'b0;

    lane_wr = lane_q;
    lane_wr[LW'(UNR - 1) - lcnt_q] = in_data_i;

    // Back-to-back strobes would merge, so the cycle after a shift never shifts.
    block  = sh_en_q || (wv_q && !win_ready_i);
    accept = in_valid_i && in_ready_o;

    if (sh_en_q && (grp_q != 4'(WARM_GRP))) begin
      grp_d = grp_q + 4'd1;
    end

    if (sh_en_q && ((state_q == StFlush) ? from_run_q : (grp_d == 4'(WARM_GRP)))) begin
      wv_d = 1'b1;
    end else if (wv_q && win_ready_i) begin
      wv_d = 1'b0;
    end

    unique case (state_q)
      StFill, StRun: begin
        if (flush_i) begin
          state_d    = StFlush;
          from_run_d = (grp_d == 4'(WARM_GRP));
          fcnt_d     = '0;
        end else begin
          state_d = (grp_d == 4'(WARM_GRP)) ? StRun : StFill;
          if (pend_q) begin
            if (!block) begin
              sh_en_d  = 1'b1;
              sh_din_d = lane_q;
              lane_d   = '0;
              pend_d   = 1'b0;
            end
          end else if (accept) begin
            if (lcnt_q == LW'(UNR - 1)) begin
              lcnt_d = '0;
              if (!block) begin
                sh_en_d  = 1'b1;
                sh_din_d = lane_wr;
                lane_d   = '0;
              end else begin
                lane_d = lane_wr;
                pend_d = 1'b1;
              end
            end else begin
              lcnt_d = lcnt_q + LW'(1);
              lane_d = lane_wr;
            end
          end
        end
      end
      StFlush: begin
        // Lane register is zero after every shift, so partial/zero groups need no masking.
        if (fcnt_q < FW'(FLUSH_GRP)) begin
          if (!block) begin
            sh_en_d  = 1'b1;
            sh_din_d = lane_q;
            lane_d   = '0;
            pend_d   = 1'b0;
            lcnt_d   = '0;
            fcnt_d   = fcnt_q + FW'(1);
          end
        end else if (!sh_en_q && (!from_run_q || (wv_q && win_ready_i))) begin
          done_d  = 1'b1;
          state_d = StFill;
          grp_d   = '0;
          lcnt_d  = '0;
          wv_d    = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StFill;
      lcnt_q     <= '0;
      grp_q      <= '0;
      lane_q     <= '0;
      pend_q     <= 1'b0;
      sh_en_q    <= 1'b0;
      sh_din_q   <= '0;
      wv_q       <= 1'b0;
      fcnt_q     <= '0;
      from_run_q <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcnt_q     <= lcnt_d;
      grp_q      <= grp_d;
      lane_q     <= lane_d;
      pend_q     <= pend_d;
      sh_en_q    <= sh_en_d;
      sh_din_q   <= sh_din_d;
      wv_q       <= wv_d;
      fcnt_q     <= fcnt_d;
      from_run_q <= from_run_d;
      done_q     <= done_d;
      rdy_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shreg_seq.sv
// Bench for shreg_seq: sample-queue model checked every cycle plus directed literal checks.
// Inputs change at posedge+1, outputs are sampled at negedge.
module tb_shreg_seq;

  localparam int DW    = 15;
  localparam int UNR   = 4;
  localparam int WARM  = 10;
  localparam int FG    = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          win_ready = 1'b1;
  logic          in_ready, sh_en, win_valid, busy_flush, flush_done;
  logic [DW*UNR-1:0] sh_din;
  logic [3:0]    grp_cnt;

  int nvec = 0;
  int nerr = 0;

  shreg_seq #(.DWIDTH(DW), .UNR(UNR), .NTAP(37)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .flush_i(flush), .win_ready_i(win_ready), .sh_en_o(sh_en),
    .sh_din_o(sh_din), .win_valid_o(win_valid), .busy_flush_o(busy_flush),
    .flush_done_o(flush_done), .grp_cnt_o(grp_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW*UNR-1:0] pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c, input logic [DW-1:0] d);
    return {a, b, c, d};
  endfunction

  // Model: queue of accepted samples; every shift must carry the oldest UNR of them.
  logic [DW-1:0]     mq[$];
  logic [DW*UNR-1:0] m_din = '0;
  logic [DW*UNR-1:0] fl_first = '0;
  bit m_rdy = 0, m_fl = 0, m_fr = 0, m_wv = 0, p_stall = 0, p_shen = 0, run_done_next = 0;
  int m_grp = 0, m_fg = 0, fwin = 0, shen_total = 0, done_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctl", {in_ready, sh_en, win_valid, busy_flush, flush_done, grp_cnt}, '0);
      check("rst_din", sh_din, '0);
      mq.delete();
      m_din = '0; m_rdy = 0; m_fl = 0; m_fr = 0; m_wv = 0; p_stall = 0; p_shen = 0;
      run_done_next = 0; m_grp = 0; m_fg = 0; fwin = 0;
    end else begin
      bit exp_done, exp_rd, nwv, shen_ok;
      int next_grp;
      exp_done = run_done_next;
      run_done_next = 0;
      if (m_fl && !m_fr && fwin > 0) begin
        if (flush_done) begin
          m_fl = 0; m_grp = 0; m_fg = 0; fwin = 0; done_seen++; mq.delete();
        end else begin
          fwin--;
          if (fwin == 0) check("flush_done_late", flush_done, 1'b1);
        end
      end else begin
        check("flush_done", flush_done, exp_done);
        if (exp_done) begin
          m_fl = 0; m_grp = 0; m_fg = 0; done_seen++; mq.delete();
        end
      end
      check("grp_cnt", grp_cnt, m_grp);
      check("win_valid", win_valid, m_wv);
      check("busy_flush", busy_flush, m_fl);
      shen_ok = m_fl ? (m_fg < FG) : (mq.size() >= UNR);
      if (!shen_ok) check("shen_unexpected", sh_en, 1'b0);
      next_grp = m_grp;
      if (sh_en) begin
        shen_total++;
        check("shen_gap", p_shen, 1'b0);
        check("shen_stall", p_stall, 1'b0);
        for (int k = UNR - 1; k >= 0; k--) begin
          if (mq.size() > 0) m_din[k*DW +: DW] = mq.pop_front();
          else m_din[k*DW +: DW] = '0;
        end
        check("sh_din", sh_din, m_din);
        next_grp = (m_grp < WARM) ? m_grp + 1 : WARM;
        if (m_fl) begin
          if (m_fg == 0) fl_first = m_din;
          m_fg++;
          if (m_fg == FG && !m_fr) fwin = 3;
        end
      end else begin
        check("sh_din_hold", sh_din, m_din);
      end
      exp_rd = m_rdy && !m_fl && !flush && (mq.size() < UNR);
      check("in_ready", in_ready, exp_rd);
      nwv = m_wv;
      if (sh_en && (m_fl ? m_fr : (next_grp == WARM))) nwv = 1;
      else if (m_wv && win_ready) nwv = 0;
      if (m_fl && m_fr && m_fg == FG && !sh_en && m_wv && win_ready) run_done_next = 1;
      p_stall = m_wv && !win_ready;
      p_shen  = sh_en;
      if (in_valid && exp_rd) mq.push_back(in_data);
      if (flush && !m_fl) begin
        m_fl = 1; m_fr = (next_grp == WARM); m_fg = 0;
      end
      m_wv = nwv; m_grp = next_grp; m_rdy = 1;
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit got = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!got && n < 100) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!got) check("push_timeout", got, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic wait_shen();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (sh_en) found = 1;
    end
    if (!found) check("wait_shen", sh_en, 1'b1);
  endtask

  task automatic flush_pulse();
    flush = 1'b1; in_valid = 1'b1; in_data = 15'h7abc;
    sync();
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input bit stall);
    for (int c = 0; c < 300 && done_seen == d0; c++) begin
      win_ready = stall ? ((c % 3) != 0) : 1'b1;
      flush = (c == 5);
      sync();
    end
    flush = 1'b0; win_ready = 1'b1;
    check("flush_done_seen", done_seen - d0, 1);
  endtask

  initial begin
    int base, d0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single group 1,2,3,4.
    base = shen_total;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    wait_shen();
    check("t1_din", sh_din, 60'h2000_8001_8004);
    @(negedge clk);
    check("t1_grp", grp_cnt, 4'd1);
    sync();

    // Warm-up: 40 samples in total.
    for (int i = 5; i <= 40; i++) push(DW'(i));
    @(negedge clk);
    check("t2_shen10", sh_en, 1'b1);
    check("t2_wv_lo", win_valid, 1'b0);
    check("t2_grp9", grp_cnt, 4'd9);
    @(negedge clk);
    check("t2_wv_hi", win_valid, 1'b1);
    check("t2_grp10", grp_cnt, 4'd10);
    check("t2_count", shen_total - base, 10);
    check("t2_din", sh_din, pack4(15'd37, 15'd38, 15'd39, 15'd40));
    sync();

    // Backpressure with win_ready low.
    win_ready = 1'b0;
    base = shen_total;
    for (int i = 200; i < 208; i++) push(DW'(i));
    repeat (5) @(negedge clk);
    check("t3_one_shen", shen_total - base, 1);
    check("t3_ready_lo", in_ready, 1'b0);
    check("t3_wv_held", win_valid, 1'b1);
    sync();
    win_ready = 1'b1;
    repeat (5) sync();
    check("t3_released", shen_total - base, 2);
    check("t3_din", sh_din, pack4(15'd204, 15'd205, 15'd206, 15'd207));

    // Flush from RUN with two samples in the partial group, stalled windows.
    push(15'd300);
    push(15'd301);
    base = shen_total;
    d0 = done_seen;
    flush_pulse();
    wait_done(d0, 1'b1);
    check("t4_first", fl_first, pack4(15'd300, 15'd301, 15'd0, 15'd0));
    check("t4_groups", shen_total - base, 9);
    @(negedge clk);
    check("t4_grp0", grp_cnt, 4'd0);
    check("t4_busy0", busy_flush, 1'b0);
    sync();

    // Flush from FILL.
    push(15'd400);
    base = shen_total;
    d0 = done_seen;
    flush_pulse();
    wait_done(d0, 1'b0);
    check("t5_first", fl_first, pack4(15'd400, 15'd0, 15'd0, 15'd0));
    check("t5_groups", shen_total - base, 9);

    // Reset asserted between clock edges in the middle of a flush.
    push(15'd500);
    push(15'd501);
    flush_pulse();
    repeat (4) sync();
    check("t6_busy", busy_flush, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", {in_ready, sh_en, win_valid, busy_flush, flush_done, grp_cnt}, '0);
    check("t6_rst_din", sh_din, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 11; i <= 14; i++) push(DW'(i));
    wait_shen();
    check("t6_din", sh_din, pack4(15'd11, 15'd12, 15'd13, 15'd14));
    @(negedge clk);
    check("t6_grp", grp_cnt, 4'd1);
    sync();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks wrong", nerr, nvec);
    $fatal(1);
  end

endmodule

// File: doc/shreg_seq.md
SHREG_SEQ -- requirements
Module: shreg_seq

Interface
REQ-001 Parameter DWIDTH, default 15: sample width in bits.
REQ-002 Parameter UNR, default 4: samples per shift group, and the lanes per shift.
REQ-003 Parameter NTAP, default 37: filter taps; BUFLEN = NTAP-1+UNR; WARM_GRP = ceil(BUFLEN/UNR) = 10; FLUSH_GRP = ceil((NTAP-1)/UNR) = 9.
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input sample valid.
REQ-007 in_data  in  DWIDTH  input sample.
REQ-008 in_ready  out  1  sample accepted when in_valid && in_ready.
REQ-009 flush  in  1  single-cycle drain request.
REQ-010 win_ready  in  1  downstream accepts the current window.
REQ-011 sh_en  out  1  one-cycle shift strobe to the shift buffer.
REQ-012 sh_din  out  DWIDTH*UNR  packed lanes; lane k = bits [k*DWIDTH +: DWIDTH].
REQ-013 win_valid  out  1  buffer holds a full valid window (level, held until win_ready).
REQ-014 busy_flush  out  1  high while in FLUSH.
REQ-015 flush_done  out  1  one-cycle pulse at end of flush.
REQ-016 grp_cnt  out  4  groups shifted since reset/flush, saturating at WARM_GRP.

Function
REQ-017 FSM states FILL, RUN, FLUSH; FILL while grp_cnt < WARM_GRP, RUN once grp_cnt == WARM_GRP.
REQ-018 Lane counter lcnt 0..UNR-1 counts accepted samples; the first sample of a group goes to lane UNR-1, the last to lane 0 (lane 0 = newest).
REQ-019 On acceptance with lcnt == UNR-1: lane register complete; sh_en asserted the next cycle with sh_din = packed group; lcnt wraps to 0.
REQ-020 sh_en is exactly one cycle per group; sh_din is stable while sh_en is high and holds the last value otherwise.
REQ-021 grp_cnt increments on each sh_en and saturates at WARM_GRP; FILL->RUN occurs in the cycle grp_cnt reaches WARM_GRP.
REQ-022 In RUN, win_valid rises one cycle after each sh_en (buffer register latency) and stays high until the cycle win_valid && win_ready.
REQ-023 In FILL, win_valid stays 0.
REQ-024 Backpressure: in_ready = 0 when the group is complete but sh_en is blocked by win_valid && !win_ready; no sample is lost or duplicated.
REQ-025 Group accept, sh_en, and win_ready in the same cycle: legal; win_valid clears and re-asserts one cycle after sh_en.
REQ-026 On flush in FILL/RUN, enter FLUSH; in_ready = 0 throughout FLUSH.
REQ-027 FLUSH, partial group (lcnt != 0): zero-pad the remaining lanes and shift; this counts as the first flush group.
REQ-028 FLUSH then issues zero groups until FLUSH_GRP groups in total have been shifted; each group obeys the win_valid/win_ready stall rule when flush began in RUN.
REQ-029 After the last flush group has been shifted (and, when flush began in RUN, its window accepted): flush_done pulses, grp_cnt = 0, lcnt = 0, go to FILL.
REQ-030 flush while busy_flush is ignored; flush with in_valid in the same cycle: flush wins and the sample is not accepted.

Reset
REQ-031 RST low: asynchronously clear state to FILL, lcnt = 0, grp_cnt = 0, lane register = 0, and all outputs 0 (in_ready = 0 while RST low).
REQ-032 First rising CLK edge after RST release: in_ready = 1. Reset mid-flush or mid-group discards the partial group with no sh_en.

Verification
REQ-033 Reset, then 4 samples 1,2,3,4 back-to-back -> one sh_en, sh_din lanes 3..0 = 1,2,3,4, grp_cnt = 1.
REQ-034 Stream 40 samples with win_ready = 1 -> 10 sh_en, win_valid first high one cycle after the 10th sh_en, RUN entered.
REQ-035 In RUN, hold win_ready = 0, stream 8 samples -> one sh_en, in_ready drops after the next full group, no further sh_en; release win_ready -> pending group shifts and data order is intact.
REQ-036 In RUN, lcnt = 2, flush -> first group lanes 3,2 = data and lanes 1,0 = 0, then 8 all-zero groups, flush_done after the 9th window is accepted, grp_cnt = 0.
REQ-037 Assert RST low mid-FLUSH on a non-edge -> outputs 0 immediately; after release, 4 samples -> normal sh_en with grp_cnt = 1.
